// File: rtl/string_detector_pkg.sv
// Shared state encoding and pattern constant for the serial "1011" detector.
package string_detector_pkg;

    localparam int         STATE_W = 3;
    localparam logic [3:0] PATTERN = 4'b1011;

    // Each state names the prefix of PATTERN matched so far.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_1011 = 3'd4
    } state_t;

endpackage

// File: rtl/string_detector.sv
// Serial "1011" detector with overlapping matches; Mealy or Moore output chosen at elaboration.
module string_detector
    import string_detector_pkg::*;
#(
    parameter int FSM_MEALY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic match
);

    localparam bit IS_MEALY = (FSM_MEALY != 0);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: state_nxt = din ? S_1   : S_IDLE;
            S_1:    state_nxt = din ? S_1   : S_10;
            S_10:   state_nxt = din ? S_101 : S_IDLE;
            // Mealy reports the hit now and keeps the trailing '1' as a fresh prefix.
            S_101:  state_nxt = din ? (IS_MEALY ? S_1 : S_1011) : S_10;
            S_1011: state_nxt = IS_MEALY ? S_IDLE : (din ? S_1 : S_10);
            default: state_nxt = S_IDLE;
        endcase
    end

    generate
        if (IS_MEALY) begin : g_mealy
            assign match = (state == S_101) && (din == PATTERN[0]);
        end else begin : g_moore
            assign match = (state == S_1011);
        end
    endgenerate

endmodule

// File: tb/tb_string_detector.sv
// Bench for string_detector: Mealy and Moore instances share one stimulus stream.
module tb_string_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic match_mealy;
    logic match_moore;

    int checks = 0;
    int failures = 0;
    int moore_pulses = 0;
    bit moore_q[$];

    typedef struct {
        bit din;
        bit exp_match;
    } vec_t;

    vec_t vecs[26];

    string_detector #(.FSM_MEALY(1)) u_mealy (
        .clk(clk), .rst_n(rst_n), .din(din), .match(match_mealy)
    );
    string_detector #(.FSM_MEALY(0)) u_moore (
        .clk(clk), .rst_n(rst_n), .din(din), .match(match_moore)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one bit mid-cycle: Mealy is checked before the consuming edge,
    // Moore after it, with its expectation carried through the queue.
    task automatic send_bit(input bit b, input bit exp, input string name);
        bit e;
        @(negedge clk);
        din = b;
        #1;
        check({name, "_mealy"}, match_mealy, exp);
        moore_q.push_back(exp);
        @(posedge clk);
        #1;
        e = moore_q.pop_front();
        check({name, "_moore"}, match_moore, e);
        if (match_moore === 1'b1) moore_pulses++;
    endtask

    initial begin
        // 15-bit stream 101011011001011: hits on bits 6, 9, 15.
        bit [14:0] stream;
        bit [14:0] hits;
        bit [10:0] tail;
        bit [10:0] tail_hits;
        stream    = 15'b101011011001011;
        hits      = 15'b000001001000001;
        // From S_1 (Mealy) / S_1011 (Moore): 0,0,1,1,0,1,1 then 1,0,1,1.
        tail      = 11'b00110111011;
        tail_hits = 11'b00000010001;
        for (int i = 0; i < 15; i++) vecs[i] = '{stream[14-i], hits[14-i]};
        for (int i = 0; i < 11; i++) vecs[15+i] = '{tail[10-i], tail_hits[10-i]};

        // Reset held across edges.
        repeat (2) @(posedge clk);
        #1;
        check("reset_mealy", match_mealy, 1'b0);
        check("reset_moore", match_moore, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            send_bit(vecs[i].din, vecs[i].exp_match, $sformatf("stream%0d", i + 1));
        end
        check("moore_pulse_count", moore_pulses[0] | moore_pulses[1], 1'b1);
        checks++;
        if (moore_pulses != 3) begin
            failures++;
            $display("FAIL moore_pulses: got %0d expected 3", moore_pulses);
        end

        for (int i = 15; i < 26; i++) begin
            send_bit(vecs[i].din, vecs[i].exp_match, $sformatf("tail%0d", i - 14));
        end

        // Mid-pattern reset: 1,0,1 then async reset while the final '1' is on din.
        send_bit(1'b0, 1'b0, "pre0");
        send_bit(1'b0, 1'b0, "pre1");
        send_bit(1'b1, 1'b0, "mid1");
        send_bit(1'b0, 1'b0, "mid2");
        send_bit(1'b1, 1'b0, "mid3");
        @(negedge clk);
        din = 1'b1;
        #1;
        check("mid_before_rst_mealy", match_mealy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_mealy", match_mealy, 1'b0);
        check("async_rst_moore", match_moore, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold_mealy", match_mealy, 1'b0);
        check("rst_hold_moore", match_moore, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        din = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_moore", match_moore, 1'b0);
        send_bit(1'b1, 1'b0, "post1");
        send_bit(1'b0, 1'b0, "post2");
        send_bit(1'b1, 1'b0, "post3");
        send_bit(1'b1, 1'b1, "post4");
        send_bit(1'b0, 1'b0, "post5");

        checks++;
        if (moore_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", moore_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
